// File: rtl/fpu_pkg.sv
// Shared constants, FSM state encoding and operand classifiers for the C&P FPU units.
package fpu_pkg;

    localparam int          BIAS    = 127;
    localparam logic [7:0]  EXP_MAX = 8'hFF;
    localparam logic [31:0] QNAN    = 32'hFFC00000;

    typedef enum logic [2:0] {
        IDLE,
        PREP,
        ITER,
        ROUND,
        DONE
    } state_t;

    function automatic logic is_nan(input logic [31:0] x);
        return (x[30:23] == EXP_MAX) && (x[22:0] != 23'd0);
    endfunction

    function automatic logic is_inf(input logic [31:0] x);
        return (x[30:23] == EXP_MAX) && (x[22:0] == 23'd0);
    endfunction

    // Subnormals are flushed, so exponent zero alone means zero.
    function automatic logic is_zero(input logic [31:0] x);
        return x[30:23] == 8'd0;
    endfunction

endpackage

// File: rtl/fdiv_mant_step.sv
// One radix-2 restoring division step on the 26-bit partial remainder.
module fdiv_mant_step (
    input  logic [25:0] rem_i,
    input  logic [25:0] div_i,
    output logic [25:0] rem_o,
    output logic        q_o
);

    logic [25:0] trial;

    // rem < 2*div keeps trial within -2^24..2^25, so bit 25 is a valid sign.
    assign trial = rem_i - div_i;
    assign q_o   = ~trial[25];
    assign rem_o = q_o ? {trial[24:0], 1'b0} : {rem_i[24:0], 1'b0};

endmodule

// File: rtl/fdiv_seq.sv
// Iterative binary32 divider y = x1 / x2 with valid/ready handshakes on both sides.
module fdiv_seq
    import fpu_pkg::*;
#(
    parameter int QBITS = 25,
    parameter int BIAS  = fpu_pkg::BIAS
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [31:0] x1,
    input  logic [31:0] x2,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [31:0] y,
    output logic        ovf
);

    localparam logic signed [9:0] BIAS_S  = 10'(BIAS);
    localparam logic signed [9:0] E_OVF   = 10'sd255;
    localparam logic [4:0]        CNT_END = 5'(QBITS - 1);

    state_t             state_q, state_d;
    logic [31:0]        x1_q, x1_d, x2_q, x2_d;
    logic [25:0]        rem_q, rem_d, div_q, div_d;
    logic [24:0]        q_q, q_d;
    logic [4:0]         cnt_q, cnt_d;
    logic signed [9:0]  e_q, e_d;
    logic [31:0]        y_q, y_d;
    logic               ovf_q, ovf_d;
    logic               out_valid_q, out_valid_d;

    logic               sy, special, lt, inc, carry;
    logic [31:0]        spec_y;
    logic [23:0]        m1, m2;
    logic signed [9:0]  e_pre, e_r;
    logic [22:0]        frac_r;
    logic [25:0]        step_rem;
    logic               step_q;

    fdiv_mant_step u_step (
        .rem_i (rem_q),
        .div_i (div_q),
        .rem_o (step_rem),
        .q_o   (step_q)
    );

    assign sy = x1_q[31] ^ x2_q[31];
    assign m1 = {1'b1, x1_q[22:0]};
    assign m2 = {1'b1, x2_q[22:0]};
    assign lt = m1 < m2;

    // Special-operand classification; priority order matters (NaN, Inf/Inf, 0/0 first).
    always_comb begin
        special = 1'b1;
        spec_y  = QNAN;
        if (is_nan(x1_q) || is_nan(x2_q) || (is_inf(x1_q) && is_inf(x2_q)) ||
            (is_zero(x1_q) && is_zero(x2_q))) begin
            spec_y = QNAN;
        end else if (is_inf(x1_q) || is_zero(x2_q)) begin
            spec_y = {sy, EXP_MAX, 23'd0};
        end else if (is_inf(x2_q) || is_zero(x1_q)) begin
            spec_y = {sy, 31'd0};
        end else begin
            special = 1'b0;
        end
    end

    assign e_pre = $signed({2'b00, x1_q[30:23]}) - $signed({2'b00, x2_q[30:23]})
                 + BIAS_S - $signed({9'd0, lt});

    // Round to nearest even; q[24] is always 1, so an all-ones q[24:1] carries to 2.0.
    assign inc    = q_q[0] && ((rem_q != 26'd0) || q_q[1]);
    assign carry  = inc && (&q_q[24:1]);
    assign frac_r = q_q[23:1] + {22'd0, inc};
    assign e_r    = e_q + $signed({9'd0, carry});

    always_comb begin
        state_d     = state_q;
        x1_d        = x1_q;
        x2_d        = x2_q;
        rem_d       = rem_q;
        div_d       = div_q;
        q_d         = q_q;
        cnt_d       = cnt_q;
        e_d         = e_q;
        y_d         = y_q;
        ovf_d       = ovf_q;
        out_valid_d = out_valid_q;
        case (state_q)
            IDLE: begin
                if (in_valid) begin
                    x1_d    = x1;
                    x2_d    = x2;
                    state_d = PREP;
                end
            end
            PREP: begin
                if (special) begin
                    y_d     = spec_y;
                    ovf_d   = 1'b0;
                    state_d = DONE;
                end else begin
                    rem_d   = lt ? {1'b0, m1, 1'b0} : {2'b00, m1};
                    div_d   = {2'b00, m2};
                    e_d     = e_pre;
                    q_d     = 25'd0;
                    cnt_d   = 5'd0;
                    state_d = ITER;
                end
            end
            ITER: begin
                rem_d = step_rem;
                q_d   = {q_q[23:0], step_q};
                cnt_d = cnt_q + 5'd1;
                if (cnt_q == CNT_END) begin
                    state_d = ROUND;
                end
            end
            ROUND: begin
                if (e_r >= E_OVF) begin
                    y_d   = {sy, EXP_MAX, 23'd0};
                    ovf_d = 1'b1;
                end else if (e_r <= 10'sd0) begin
                    y_d   = {sy, 31'd0};
                    ovf_d = 1'b0;
                end else begin
                    y_d   = {sy, e_r[7:0], frac_r};
                    ovf_d = 1'b0;
                end
                state_d = DONE;
            end
            DONE: begin
                // Result register stage: out_valid rises one cycle after DONE is entered.
                if (!out_valid_q) begin
                    out_valid_d = 1'b1;
                end else if (out_ready) begin
                    out_valid_d = 1'b0;
                    state_d     = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            y_q         <= 32'd0;
            ovf_q       <= 1'b0;
            out_valid_q <= 1'b0;
            cnt_q       <= 5'd0;
        end else begin
            state_q     <= state_d;
            y_q         <= y_d;
            ovf_q       <= ovf_d;
            out_valid_q <= out_valid_d;
            cnt_q       <= cnt_d;
        end
    end

    always_ff @(posedge clk) begin
        x1_q  <= x1_d;
        x2_q  <= x2_d;
        rem_q <= rem_d;
        div_q <= div_d;
        q_q   <= q_d;
        e_q   <= e_d;
    end

    assign in_ready  = (state_q == IDLE);
    assign out_valid = out_valid_q;
    assign y         = y_q;
    assign ovf       = ovf_q;

endmodule

// File: tb/tb_fdiv_seq.sv
// Directed-vector bench for fdiv_seq: results, latency, backpressure and mid-operation reset.
module tb_fdiv_seq;

    logic        clk = 1'b0;
    logic        rst, in_valid, in_ready, out_valid, out_ready, ovf;
    logic [31:0] x1, x2, y;

    int errors = 0;
    int checks = 0;

    fdiv_seq dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .x1        (x1),
        .x2        (x2),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .y         (y),
        .ovf       (ovf)
    );

    always #5 clk = ~clk;

    typedef struct {
        string       name;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] y;
        logic        ovf;
        int          lat;
    } vec_t;

    vec_t vecs[13];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    // Launch one operation and wait for out_valid; returns edges from accept to out_valid.
    task automatic do_op(input string name, input logic [31:0] a, input logic [31:0] b,
                         output int lat);
        bit busy_bad;
        chk({name, " in_ready before accept"}, {31'd0, in_ready}, 32'd1);
        x1 = a;
        x2 = b;
        in_valid = 1'b1;
        @(posedge clk);
        #1 in_valid = 1'b0;
        lat = 0;
        busy_bad = 1'b0;
        while (!out_valid && lat < 40) begin
            if (in_ready) busy_bad = 1'b1;
            @(posedge clk);
            #1 lat++;
        end
        if (!out_valid) lat = -1;
        chk({name, " in_ready low while busy"}, {31'd0, busy_bad}, 32'd0);
        chk({name, " in_ready low in DONE"}, {31'd0, in_ready}, 32'd0);
    endtask

    task automatic release_out(input string name);
        out_ready = 1'b1;
        @(posedge clk);
        #1 out_ready = 1'b0;
        chk({name, " out_valid after handshake"}, {31'd0, out_valid}, 32'd0);
        chk({name, " in_ready after handshake"}, {31'd0, in_ready}, 32'd1);
    endtask

    initial begin
        int lat;

        vecs[0]  = '{"6/2",      32'h40C00000, 32'h40000000, 32'h40400000, 1'b0, 28};
        vecs[1]  = '{"1/3",      32'h3F800000, 32'h40400000, 32'h3EAAAAAB, 1'b0, 28};
        vecs[2]  = '{"overflow", 32'h7F000000, 32'h3E800000, 32'h7F800000, 1'b1, 28};
        vecs[3]  = '{"underflow",32'h00800000, 32'h4B000000, 32'h00000000, 1'b0, 28};
        vecs[4]  = '{"1/-0",     32'h3F800000, 32'h80000000, 32'hFF800000, 1'b0, 2};
        vecs[5]  = '{"0/0",      32'h00000000, 32'h00000000, 32'hFFC00000, 1'b0, 2};
        vecs[6]  = '{"inf/inf",  32'h7F800000, 32'h7F800000, 32'hFFC00000, 1'b0, 2};
        vecs[7]  = '{"nan/1",    32'h7FC00001, 32'h3F800000, 32'hFFC00000, 1'b0, 2};
        vecs[8]  = '{"1/1",      32'h3F800000, 32'h3F800000, 32'h3F800000, 1'b0, 28};
        vecs[9]  = '{"-6/2",     32'hC0C00000, 32'h40000000, 32'hC0400000, 1'b0, 28};
        vecs[10] = '{"-inf/2",   32'hFF800000, 32'h40000000, 32'hFF800000, 1'b0, 2};
        vecs[11] = '{"2/inf",    32'h40000000, 32'h7F800000, 32'h00000000, 1'b0, 2};
        vecs[12] = '{"subn/1",   32'h00000001, 32'h3F800000, 32'h00000000, 1'b0, 2};

        rst = 1'b1;
        in_valid = 1'b0;
        out_ready = 1'b0;
        x1 = 32'd0;
        x2 = 32'd0;
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        chk("reset in_ready", {31'd0, in_ready}, 32'd1);
        chk("reset out_valid", {31'd0, out_valid}, 32'd0);
        chk("reset y", y, 32'd0);
        chk("reset ovf", {31'd0, ovf}, 32'd0);

        for (int i = 0; i < 13; i++) begin
            do_op(vecs[i].name, vecs[i].a, vecs[i].b, lat);
            chk({vecs[i].name, " latency"}, lat, vecs[i].lat);
            chk({vecs[i].name, " y"}, y, vecs[i].y);
            chk({vecs[i].name, " ovf"}, {31'd0, ovf}, {31'd0, vecs[i].ovf});
            release_out(vecs[i].name);
        end

        // Backpressure: stall 5 cycles with an ignored in_valid pulse in the middle.
        do_op("stall", 32'h7F000000, 32'h3E800000, lat);
        chk("stall latency", lat, 28);
        for (int c = 0; c < 5; c++) begin
            if (c == 2) begin
                x1 = 32'h3F800000;
                x2 = 32'h40400000;
                in_valid = 1'b1;
            end else begin
                in_valid = 1'b0;
            end
            @(posedge clk);
            #1;
            chk("stall out_valid", {31'd0, out_valid}, 32'd1);
            chk("stall y", y, 32'h7F800000);
            chk("stall ovf", {31'd0, ovf}, 32'd1);
            chk("stall in_ready", {31'd0, in_ready}, 32'd0);
        end
        in_valid = 1'b0;
        release_out("stall");
        @(posedge clk);
        #1;
        chk("stall pulse not accepted", {31'd0, in_ready}, 32'd1);

        // Reset in the middle of ITER; y/ovf still hold the overflow result beforehand.
        x1 = 32'h40C00000;
        x2 = 32'h40000000;
        in_valid = 1'b1;
        @(posedge clk);
        #1 in_valid = 1'b0;
        repeat (11) @(posedge clk);
        #1 rst = 1'b1;
        @(posedge clk);
        #1 rst = 1'b0;
        chk("midrst out_valid", {31'd0, out_valid}, 32'd0);
        chk("midrst in_ready", {31'd0, in_ready}, 32'd1);
        chk("midrst y", y, 32'd0);
        chk("midrst ovf", {31'd0, ovf}, 32'd0);

        do_op("after rst", 32'h40C00000, 32'h40000000, lat);
        chk("after rst latency", lat, 28);
        chk("after rst y", y, 32'h40400000);
        chk("after rst ovf", {31'd0, ovf}, 32'd0);
        release_out("after rst");

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
